// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller:
// FSM encoding, RV32I opcodes and the control-output bundle.
package hazard_defs;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_wr;
        logic mem_wb_wr;
        logic mem_err;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = ctrl_t'(7'b1100110);
    localparam ctrl_t CTRL_STALL = ctrl_t'(7'b0001110);
    localparam ctrl_t CTRL_BR    = ctrl_t'(7'b1111110);
    localparam ctrl_t CTRL_FLUSH = ctrl_t'(7'b1110110);
    localparam ctrl_t CTRL_HOLD  = ctrl_t'(7'b0000000);
    localparam ctrl_t CTRL_ERR   = ctrl_t'(7'b0000001);
    localparam ctrl_t CTRL_RST   = ctrl_t'(7'b0011000);

    function automatic logic uses_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OP_R, OP_STORE, OP_BRANCH: r = 1'b1;
            OP_LOAD, OP_SYSTEM:        r = 1'b0;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-detect inputs and stage-control outputs between
// the datapath (master) and the stall controller (slave).
interface hazard_stall_ctrl_if;
    logic       ID_EX_mem_rd;
    logic [4:0] ID_EX_Rd;
    logic [4:0] IF_ID_Rs1;
    logic [4:0] IF_ID_Rs2;
    logic [6:0] IF_ID_Op;
    logic       branch_taken;
    logic       dmem_busy;
    logic       PC_wr;
    logic       IF_ID_wr;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       EX_MEM_wr;
    logic       MEM_WB_wr;
    logic       mem_err;

    modport master (
        output ID_EX_mem_rd, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2,
        output IF_ID_Op, branch_taken, dmem_busy,
        input  PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush,
        input  EX_MEM_wr, MEM_WB_wr, mem_err
    );

    modport slave (
        input  ID_EX_mem_rd, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2,
        input  IF_ID_Op, branch_taken, dmem_busy,
        output PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush,
        output EX_MEM_wr, MEM_WB_wr, mem_err
    );
endinterface

// File: rtl/hazard_stall_ctrl_perf_cnt.sv
// Free-running 32-bit stall-cycle and taken-branch counters,
// present only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q + {31'd0, stall_inc};
        flush_d = flush_q + {31'd0, flush_inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / dmem-wait sequencer for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add stall_cycles and flush_count outputs.
module hazard_stall_ctrl
    import hazard_defs::*;
#(
    parameter int LU_BUBBLES   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic clk,
    input  logic rst,
    hazard_stall_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam logic [7:0] TMO   = 8'(MEM_TIMEOUT);
    localparam logic [1:0] LU_N  = 2'(LU_BUBBLES - 1);
    localparam logic [1:0] FL_N  = 2'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    state_e     cur;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    ctrl_t      ctrl;
    logic       lu;
    logic       rs1_hit, rs2_hit;

    assign rs1_hit = hz.ID_EX_Rd == hz.IF_ID_Rs1;
    assign rs2_hit = (hz.ID_EX_Rd == hz.IF_ID_Rs2) && uses_rs2(hz.IF_ID_Op);
    assign lu = hz.ID_EX_mem_rd && (hz.ID_EX_Rd != 5'd0) && (rs1_hit || rs2_hit);

    // Memory ready in MEM_WAIT: act this very cycle as the state we left.
    assign cur = (state_q == MEM_WAIT && !hz.dmem_busy) ? ret_q : state_q;

    always_comb begin
        state_d    = cur;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = CTRL_RUN;
        if (state_q == MEM_WAIT && hz.dmem_busy) begin
            ctrl = CTRL_HOLD;
            if (wait_cnt_q == TMO) begin
                ctrl    = CTRL_ERR;
                state_d = RUN;
                cnt_d   = '0;
            end else if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else if (hz.dmem_busy) begin
            ctrl       = CTRL_HOLD;
            ret_d      = cur;
            wait_cnt_d = 8'd1;
            state_d    = MEM_WAIT;
        end else if (hz.branch_taken) begin
            ctrl = CTRL_BR;
            if (FLUSH_CYCLES == 0) begin
                state_d = RUN;
            end else begin
                state_d = FLUSH;
                cnt_d   = FL_N;
            end
        end else if (cur == LU_STALL) begin
            ctrl = CTRL_STALL;
            if (cnt_q == 2'd1) state_d = RUN;
            else cnt_d = cnt_q - 2'd1;
        end else if (cur == FLUSH) begin
            ctrl = CTRL_FLUSH;
            if (cnt_q == 2'd1) state_d = RUN;
            else cnt_d = cnt_q - 2'd1;
        end else if (lu) begin
            ctrl = CTRL_STALL;
            if (LU_BUBBLES > 1) begin
                state_d = LU_STALL;
                cnt_d   = LU_N;
            end
        end
        if (rst) ctrl = CTRL_RST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ret_q      <= RUN;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hz.PC_wr       = ctrl.pc_wr;
    assign hz.IF_ID_wr    = ctrl.if_id_wr;
    assign hz.IF_ID_flush = ctrl.if_id_flush;
    assign hz.ID_EX_flush = ctrl.id_ex_flush;
    assign hz.EX_MEM_wr   = ctrl.ex_mem_wr;
    assign hz.MEM_WB_wr   = ctrl.mem_wb_wr;
    assign hz.mem_err     = ctrl.mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic br_acc;
    assign br_acc = !rst && !hz.dmem_busy && hz.branch_taken;

    hazard_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (!ctrl.pc_wr),
        .flush_inc    (br_acc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controllers with different bubble/flush/timeout
// settings share stimulus; expected control vectors are queued per cycle.
module tb_hazard_stall_ctrl;
    import hazard_defs::*;

    // {PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, EX_MEM_wr, MEM_WB_wr, mem_err}
    localparam logic [6:0] V_RUN   = 7'b1100110;
    localparam logic [6:0] V_STALL = 7'b0001110;
    localparam logic [6:0] V_BR    = 7'b1111110;
    localparam logic [6:0] V_FL    = 7'b1110110;
    localparam logic [6:0] V_WAIT  = 7'b0000000;
    localparam logic [6:0] V_ERR   = 7'b0000001;
    localparam logic [6:0] V_RST   = 7'b0011000;

    typedef struct {
        logic [6:0] ea;
        logic [6:0] eb;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl_if ifa ();
    hazard_stall_ctrl_if ifb ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    hazard_stall_ctrl #(
        .LU_BUBBLES(1), .FLUSH_CYCLES(1), .MEM_TIMEOUT(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (ifa.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (sc_a),
        .flush_count  (fc_a)
`endif
    );

    hazard_stall_ctrl #(
        .LU_BUBBLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(255)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (ifb.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (sc_b),
        .flush_count  (fc_b)
`endif
    );

    logic [6:0] obs_a, obs_b;
    assign obs_a = {ifa.PC_wr, ifa.IF_ID_wr, ifa.IF_ID_flush, ifa.ID_EX_flush,
                    ifa.EX_MEM_wr, ifa.MEM_WB_wr, ifa.mem_err};
    assign obs_b = {ifb.PC_wr, ifb.IF_ID_wr, ifb.IF_ID_flush, ifb.ID_EX_flush,
                    ifb.EX_MEM_wr, ifb.MEM_WB_wr, ifb.mem_err};

    task automatic set_in(input logic mrd, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] op, input logic br,
                          input logic busy);
        ifa.ID_EX_mem_rd = mrd; ifb.ID_EX_mem_rd = mrd;
        ifa.ID_EX_Rd     = rd;  ifb.ID_EX_Rd     = rd;
        ifa.IF_ID_Rs1    = rs1; ifb.IF_ID_Rs1    = rs1;
        ifa.IF_ID_Rs2    = rs2; ifb.IF_ID_Rs2    = rs2;
        ifa.IF_ID_Op     = op;  ifb.IF_ID_Op     = op;
        ifa.branch_taken = br;  ifb.branch_taken = br;
        ifa.dmem_busy    = busy; ifb.dmem_busy   = busy;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b0, 1'b0);
    endtask

    // Inputs are already driven; queue this cycle's expectation and
    // check it mid-cycle, then step to just after the next edge.
    task automatic cyc(input logic [6:0] ea, input logic [6:0] eb,
                       input string nm);
        exp_t e;
        sb.push_back('{ea, eb, nm});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs_a !== e.ea) begin
            errors++;
            $display("FAIL %s dut_a: got %b expected %b", e.nm, obs_a, e.ea);
        end
        checks++;
        if (obs_b !== e.eb) begin
            errors++;
            $display("FAIL %s dut_b: got %b expected %b", e.nm, obs_b, e.eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc(V_RST, V_RST, "reset_0");
        cyc(V_RST, V_RST, "reset_1");
        rst = 1'b0;
        cyc(V_RUN, V_RUN, "reset_release");
    endtask

    task automatic lu_case(input logic [6:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic stall, input string nm);
        set_in(1'b1, rd, rs1, rs2, op, 1'b0, 1'b0);
        if (stall) begin
            cyc(V_STALL, V_STALL, nm);
            idle();
            cyc(V_RUN, V_STALL, {nm, "_b2"});
            cyc(V_RUN, V_STALL, {nm, "_b3"});
            cyc(V_RUN, V_RUN, {nm, "_done"});
        end else begin
            cyc(V_RUN, V_RUN, nm);
            idle();
        end
    endtask

    task automatic test_load_use();
        lu_case(OP_R,      5'd1,  5'd5,  5'd5,  1'b1, "lu_add_rs2");
        lu_case(OP_STORE,  5'd2,  5'd9,  5'd9,  1'b1, "lu_store_rs2");
        lu_case(OP_BRANCH, 5'd3,  5'd12, 5'd12, 1'b1, "lu_branch_rs2");
        lu_case(OP_LOAD,   5'd7,  5'd0,  5'd7,  1'b1, "lu_load_rs1");
        lu_case(OP_LOAD,   5'd3,  5'd5,  5'd5,  1'b0, "nolu_load_rs2");
        lu_case(OP_SYSTEM, 5'd0,  5'd7,  5'd7,  1'b0, "nolu_sys_rs2");
        lu_case(OP_R,      5'd0,  5'd0,  5'd0,  1'b0, "nolu_x0");
        set_in(1'b0, 5'd5, 5'd5, 5'd5, OP_R, 1'b0, 1'b0);
        cyc(V_RUN, V_RUN, "nolu_not_load");
        idle();
    endtask

    task automatic test_branch_vs_lu();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, OP_R, 1'b1, 1'b0);
        cyc(V_BR, V_BR, "br_lu_same");
        set_in(1'b1, 5'd5, 5'd5, 5'd0, OP_R, 1'b0, 1'b0);
        cyc(V_FL, V_FL, "br_flush_1");
        idle();
        cyc(V_RUN, V_FL, "br_flush_2");
        cyc(V_RUN, V_RUN, "br_done");
    endtask

    task automatic test_branch_aborts_stall();
        set_in(1'b1, 5'd6, 5'd6, 5'd0, OP_R, 1'b0, 1'b0);
        cyc(V_STALL, V_STALL, "abort_lu");
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b1, 1'b0);
        cyc(V_BR, V_BR, "abort_br");
        idle();
        cyc(V_FL, V_FL, "abort_fl1");
        cyc(V_RUN, V_FL, "abort_fl2");
        cyc(V_RUN, V_RUN, "abort_done");
    endtask

    task automatic test_mem_wait();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(V_WAIT, V_WAIT, "mw_busy");
        idle();
        cyc(V_RUN, V_RUN, "mw_resume");
        cyc(V_RUN, V_RUN, "mw_after");
    endtask

    task automatic test_wait_in_stall();
        set_in(1'b1, 5'd4, 5'd4, 5'd0, OP_R, 1'b0, 1'b0);
        cyc(V_STALL, V_STALL, "ws_lu");
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b0, 1'b1);
        cyc(V_WAIT, V_WAIT, "ws_busy1");
        cyc(V_WAIT, V_WAIT, "ws_busy2");
        idle();
        cyc(V_RUN, V_STALL, "ws_resume");
        cyc(V_RUN, V_STALL, "ws_last");
        cyc(V_RUN, V_RUN, "ws_done");
    endtask

    task automatic test_timeout();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) cyc(V_WAIT, V_WAIT, "to_wait");
        cyc(V_ERR, V_WAIT, "to_err");
        cyc(V_WAIT, V_WAIT, "to_err_once");
        idle();
        cyc(V_RUN, V_RUN, "to_resume");
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b0, 1'b1);
        cyc(V_WAIT, V_WAIT, "rm_busy1");
        cyc(V_WAIT, V_WAIT, "rm_busy2");
        rst = 1'b1;
        cyc(V_RST, V_RST, "rm_rst_busy");
        idle();
        cyc(V_RST, V_RST, "rm_rst_idle");
        rst = 1'b0;
        cyc(V_RUN, V_RUN, "rm_run");
        set_in(1'b1, 5'd8, 5'd8, 5'd0, OP_R, 1'b0, 1'b0);
        cyc(V_STALL, V_STALL, "rm_lu");
        rst = 1'b1;
        idle();
        cyc(V_RST, V_RST, "rm_rst_stall");
        rst = 1'b0;
        cyc(V_RUN, V_RUN, "rm_no_residual");
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 5'd5, 5'd5, 5'd0, OP_R, 1'b0, 1'b0);
        cyc(V_STALL, V_STALL, "b2b_lu1");
        cyc(V_STALL, V_STALL, "b2b_lu2");
        idle();
        cyc(V_RUN, V_STALL, "b2b_tail");
        cyc(V_RUN, V_RUN, "b2b_done");
        set_in(1'b0, 5'd0, 5'd0, 5'd0, OP_SYSTEM, 1'b1, 1'b1);
        cyc(V_WAIT, V_WAIT, "b2b_busy_over_br");
        idle();
        cyc(V_RUN, V_RUN, "b2b_busy_release");
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_branch_aborts_stall();
        test_mem_wait();
        test_wait_in_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
